// File: rtl/bp_io_host_responder_if.sv
// BedRock I/O command/response channel between the link endpoint (master)
// and the host-side responder (slave).
interface bp_io_host_responder_if
  #(parameter int paddr_width_p   = 40,
    parameter int data_width_p    = 64,
    parameter int payload_width_p = 16);

  // Command channel, ready-valid
  logic [3:0]                 cmd_msg_type_i;
  logic [paddr_width_p-1:0]   cmd_addr_i;
  logic [2:0]                 cmd_size_i;
  logic [payload_width_p-1:0] cmd_payload_i;
  logic [data_width_p-1:0]    cmd_data_i;
  logic                       cmd_v_i;
  logic                       cmd_ready_o;

  // Response channel, valid-yumi
  logic [3:0]                 resp_msg_type_o;
  logic [paddr_width_p-1:0]   resp_addr_o;
  logic [2:0]                 resp_size_o;
  logic [payload_width_p-1:0] resp_payload_o;
  logic [data_width_p-1:0]    resp_data_o;
  logic                       resp_v_o;
  logic                       resp_yumi_i;

  modport slave (
    input  cmd_msg_type_i, cmd_addr_i, cmd_size_i, cmd_payload_i, cmd_data_i,
           cmd_v_i, resp_yumi_i,
    output cmd_ready_o, resp_msg_type_o, resp_addr_o, resp_size_o,
           resp_payload_o, resp_data_o, resp_v_o
  );

  modport master (
    output cmd_msg_type_i, cmd_addr_i, cmd_size_i, cmd_payload_i, cmd_data_i,
           cmd_v_i, resp_yumi_i,
    input  cmd_ready_o, resp_msg_type_o, resp_addr_o, resp_size_o,
           resp_payload_o, resp_data_o, resp_v_o
  );

endinterface

// File: rtl/bp_io_host_responder.sv
// Host-side responder for the BlackParrot BedRock I/O command stream.
// Serves putchar, per-core finish, getchar and a free-running cycle counter,
// returning exactly one response per command with one command outstanding.
module bp_io_host_responder
  #(parameter int paddr_width_p   = 40,
    parameter int data_width_p    = 64,
    parameter int payload_width_p = 16,
    parameter int num_core_p      = 4,
    parameter int char_fifo_els_p = 4)
  (input  logic                  clk_i,
   input  logic                  reset_n_i,
   bp_io_host_responder_if.slave io,
   output logic [7:0]            char_o,
   output logic                  char_v_o,
   input  logic                  char_ready_i,
   input  logic [7:0]            getchar_i,
   input  logic                  getchar_v_i,
   output logic                  getchar_yumi_o,
   output logic [num_core_p-1:0] finish_o,
   output logic [num_core_p-1:0] pass_o,
   output logic                  all_finished_o,
   output logic                  error_o);

  localparam int fifo_ptr_w_lp = $clog2(char_fifo_els_p);
  localparam int core_idx_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  localparam logic [15:0] putchar_addr_lp = 16'h1000;
  localparam logic [15:0] finish_addr_lp  = 16'h2000;
  localparam logic [15:0] getchar_addr_lp = 16'h3000;
  localparam logic [15:0] cycle_addr_lp   = 16'h4000;

  typedef enum logic [1:0] {e_idle, e_wait_char, e_resp} state_e;

  state_e                     state_q;
  logic [3:0]                 resp_msg_type_q;
  logic [paddr_width_p-1:0]   resp_addr_q;
  logic [2:0]                 resp_size_q;
  logic [payload_width_p-1:0] resp_payload_q;
  logic [data_width_p-1:0]    resp_data_q;
  logic [num_core_p-1:0]      finish_q;
  logic [num_core_p-1:0]      pass_q;
  logic                       error_q;
  logic [data_width_p-1:0]    cycle_q;
  logic [7:0]                 pending_char_q;

  // Putchar FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [fifo_ptr_w_lp:0]     wr_ptr_q, rd_ptr_q;
  logic [7:0]                 fifo_mem [char_fifo_els_p];
  logic                       fifo_empty, fifo_full, char_deq, enq_v;
  logic [7:0]                 enq_data;

  // Decode
  logic                       accept;
  logic [15:0]                addr_lo, finish_off;
  logic [core_idx_w_lp-1:0]   finish_idx;
  logic                       hit_putchar, hit_finish, hit_getchar, hit_cycle;
  logic                       legal_type, legal_size, cmd_err, is_load, is_store;
  logic                       do_putchar, do_finish;
  logic [data_width_p-1:0]    size_mask, load_raw, load_data;

  // Only the low byte of store data carries meaning for any device
  logic                       unused_data;
  assign unused_data = ^io.cmd_data_i[data_width_p-1:8];

  // Ready is withheld while reset is held so nothing looks acceptable then
  assign io.cmd_ready_o = (state_q == e_idle) && reset_n_i;
  assign accept         = io.cmd_ready_o && io.cmd_v_i;

  assign addr_lo     = io.cmd_addr_i[15:0];
  assign finish_off  = addr_lo - finish_addr_lp;
  assign finish_idx  = finish_off[3 +: core_idx_w_lp];
  assign hit_putchar = (addr_lo == putchar_addr_lp);
  assign hit_getchar = (addr_lo == getchar_addr_lp);
  assign hit_cycle   = (addr_lo == cycle_addr_lp);
  assign hit_finish  = (finish_off[2:0] == 3'b000)
                    && (finish_off[15:3] < 13'(num_core_p));

  assign legal_type  = (io.cmd_msg_type_i <= 4'd3);
  assign legal_size  = (io.cmd_size_i <= 3'd3);
  assign cmd_err     = !legal_type || !legal_size
                    || !(hit_putchar || hit_finish || hit_getchar || hit_cycle);
  // Types 1 (wr) and 3 (uc_wr) are stores, 0 (rd) and 2 (uc_rd) are loads
  assign is_store    = io.cmd_msg_type_i[0];
  assign is_load     = !io.cmd_msg_type_i[0];

  assign do_putchar  = accept && !cmd_err && is_store && hit_putchar;
  assign do_finish   = accept && !cmd_err && is_store && hit_finish;

  // Getchar consumes the host byte only when a legal load actually samples it
  assign getchar_yumi_o = accept && !cmd_err && is_load && hit_getchar && getchar_v_i;

  // Load data before size masking; illegal commands and stores return zero
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    load_raw = '0;
    if (!cmd_err && is_load) begin
      if (hit_getchar)
        load_raw = getchar_v_i ? data_width_p'(getchar_i) : '1;
      else if (hit_cycle)
        load_raw = cycle_q;
    end
  end

  // Byte-lane mask for the requested access size
  always_comb begin
    size_mask = '1;
    case (io.cmd_size_i[1:0])
      2'd0:    size_mask = data_width_p'(64'h0000_0000_0000_00ff);
      2'd1:    size_mask = data_width_p'(64'h0000_0000_0000_ffff);
      2'd2:    size_mask = data_width_p'(64'h0000_0000_ffff_ffff);
      default: size_mask = '1;
    endcase
  end

  assign load_data = load_raw & size_mask;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[fifo_ptr_w_lp] != rd_ptr_q[fifo_ptr_w_lp])
                   && (wr_ptr_q[fifo_ptr_w_lp-1:0] == rd_ptr_q[fifo_ptr_w_lp-1:0]);
  assign char_o     = fifo_mem[rd_ptr_q[fifo_ptr_w_lp-1:0]];
  assign char_v_o   = !fifo_empty;
  assign char_deq   = char_v_o && char_ready_i;

  // A stalled byte may enter a full FIFO in the same cycle one drains out
  assign enq_v    = (do_putchar && !fifo_full)
                 || ((state_q == e_wait_char) && (!fifo_full || char_deq));
  assign enq_data = (state_q == e_wait_char) ? pending_char_q : io.cmd_data_i[7:0];

  // FIFO storage: written on enqueue only
  always_ff @(posedge clk_i) begin
    // NOTE: storage arrays are left unreset; the reset pointers make stale data unreachable.
    if (enq_v)
      fifo_mem[wr_ptr_q[fifo_ptr_w_lp-1:0]] <= enq_data;
  end

  // Command FSM with latched response, device side effects and counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n_i) begin
      state_q         <= e_idle;
      resp_msg_type_q <= '0;
      resp_addr_q     <= '0;
      resp_size_q     <= '0;
      resp_payload_q  <= '0;
      resp_data_q     <= '0;
      finish_q        <= '0;
      pass_q          <= '0;
      error_q         <= 1'b0;
      cycle_q         <= '0;
      pending_char_q  <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      cycle_q  <= cycle_q + 1'b1;
      wr_ptr_q <= wr_ptr_q + (fifo_ptr_w_lp+1)'(enq_v);
      rd_ptr_q <= rd_ptr_q + (fifo_ptr_w_lp+1)'(char_deq);

      case (state_q)
        e_idle: begin
          if (accept) begin
            resp_msg_type_q <= io.cmd_msg_type_i;
            resp_addr_q     <= io.cmd_addr_i;
            resp_size_q     <= io.cmd_size_i;
            resp_payload_q  <= io.cmd_payload_i;
            resp_data_q     <= load_data;
            if (cmd_err)
              error_q <= 1'b1;
            if (do_finish) begin
              finish_q[finish_idx] <= 1'b1;
              pass_q[finish_idx]   <= (io.cmd_data_i[7:0] == 8'h00);
            end
            if (do_putchar && fifo_full) begin
              pending_char_q <= io.cmd_data_i[7:0];
              state_q        <= e_wait_char;
            end else begin
              state_q <= e_resp;
            end
          end
        end
        e_wait_char: begin
          if (!fifo_full || char_deq)
            state_q <= e_resp;
        end
        e_resp: begin
          if (io.resp_yumi_i)
            state_q <= e_idle;
        end
        default: state_q <= e_idle;
      endcase
    end
  end

  assign io.resp_v_o        = (state_q == e_resp);
  assign io.resp_msg_type_o = resp_msg_type_q;
  assign io.resp_addr_o     = resp_addr_q;
  assign io.resp_size_o     = resp_size_q;
  assign io.resp_payload_o  = resp_payload_q;
  assign io.resp_data_o     = resp_data_q;

  assign finish_o       = finish_q;
  assign pass_o         = pass_q;
  assign all_finished_o = &finish_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_bp_io_host_responder.sv
// Bench for bp_io_host_responder: directed scenarios then randomized commands,
// all checked against a transaction-level model of the host devices.
module tb_bp_io_host_responder;

  localparam int num_core = 4;
  localparam int fifo_els = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] char_o;
  logic       char_v_o;
  logic       char_ready_i = 1'b0;
  logic [7:0] getchar_i = 8'h00;
  logic       getchar_v_i = 1'b0;
  logic       getchar_yumi_o;
  logic [num_core-1:0] finish_o, pass_o;
  logic       all_finished_o, error_o;

  always #5 clk = ~clk;

  bp_io_host_responder_if #(.paddr_width_p(40), .data_width_p(64), .payload_width_p(16)) io ();

  bp_io_host_responder #(
    .paddr_width_p(40), .data_width_p(64), .payload_width_p(16),
    .num_core_p(num_core), .char_fifo_els_p(fifo_els)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .io(io),
    .char_o(char_o), .char_v_o(char_v_o), .char_ready_i(char_ready_i),
    .getchar_i(getchar_i), .getchar_v_i(getchar_v_i), .getchar_yumi_o(getchar_yumi_o),
    .finish_o(finish_o), .pass_o(pass_o), .all_finished_o(all_finished_o),
    .error_o(error_o)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference cycle count: edges seen since reset release
  logic [63:0] tb_cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tb_cyc <= '0;
    else          tb_cyc <= tb_cyc + 1;

  // char_ready_i driver: 0 hold, 1 always ready, 2 random
  int char_mode = 0;
  always @(negedge clk)
    char_ready_i = (char_mode == 2) ? 1'($urandom_range(0, 1)) : (char_mode == 1);

  task automatic set_char_mode(input int m);
    @(posedge clk); #2;
    char_mode = m;
  endtask

  // Model state
  logic [7:0]          exp_chars[$];
  bit                  deq_now = 0;
  logic [num_core-1:0] m_finish = '0, m_pass = '0;
  logic                m_error = 1'b0;

  logic [3:0]  e_type;
  logic [39:0] e_addr;
  logic [2:0]  e_size;
  logic [15:0] e_payload;
  logic [63:0] e_data, e_acc_cyc;
  bit          e_stall;

  // Output character monitor: each handshake must deliver the oldest byte stored
  always begin
    @(negedge clk); #1;
    deq_now = 0;
    if (reset_n && char_v_o && char_ready_i) begin
      deq_now = 1;
      if (exp_chars.size() == 0) check("char_unexpected", 64'(char_o), 64'h100);
      else                       check("char_out", 64'(char_o), 64'(exp_chars.pop_front()));
    end
  end

  // Present a command, wait for acceptance and predict its effects
  task automatic send_accept(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                             input logic [63:0] d, input logic [15:0] p,
                             input logic gv, input logic [7:0] gc);
    int a16, core, n;
    bit ok, ld, st, is_fin, mapped, exp_yumi;
    logic [63:0] v;
    @(negedge clk);
    io.cmd_msg_type_i = t;
    io.cmd_addr_i     = a;
    io.cmd_size_i     = s;
    io.cmd_data_i     = d;
    io.cmd_payload_i  = p;
    io.cmd_v_i        = 1'b1;
    getchar_v_i       = gv;
    getchar_i         = gc;
    #2;
    n = 0;
    while (!io.cmd_ready_o && n < 50) begin @(negedge clk); #2; n++; end
    check("cmd_ready", 64'(io.cmd_ready_o), 64'd1);

    a16    = int'(a[15:0]);
    is_fin = (a16 >= 'h2000) && (a16 < 'h2000 + 8 * num_core) && (a16 % 8 == 0);
    core   = (a16 - 'h2000) / 8;
    mapped = (a16 == 'h1000) || is_fin || (a16 == 'h3000) || (a16 == 'h4000);
    ok     = (t < 4) && (s < 4) && mapped;
    ld     = (t == 0) || (t == 2);
    st     = (t == 1) || (t == 3);

    v = '0;
    if (ok && ld && a16 == 'h3000) v = gv ? 64'(gc) : 64'hffff_ffff_ffff_ffff;
    if (ok && ld && a16 == 'h4000) v = tb_cyc;
    if (s < 3) v = v & ((64'd1 << (8 << s)) - 64'd1);

    e_type = t; e_addr = a; e_size = s; e_payload = p; e_data = v;
    e_acc_cyc = tb_cyc;
    exp_yumi  = ok && ld && (a16 == 'h3000) && gv;
    check("gc_yumi", 64'(getchar_yumi_o), 64'(exp_yumi));

    e_stall = 0;
    if (!ok) m_error = 1'b1;
    if (ok && st && a16 == 'h1000) begin
      e_stall = (exp_chars.size() + int'(deq_now)) >= fifo_els;
      exp_chars.push_back(d[7:0]);
    end
    if (ok && st && is_fin) begin
      m_finish[core] = 1'b1;
      m_pass[core]   = (d[7:0] == 8'h00);
    end
    @(posedge clk); #1;
    io.cmd_v_i  = 1'b0;
    getchar_v_i = 1'b0;
  endtask

  // Wait for the response, compare it and optionally retire it
  task automatic wait_resp(input bit do_yumi, input int hold, input int max_n);
    int n;
    n = 0;
    @(negedge clk); #2;
    while (!io.resp_v_o && n < max_n) begin @(negedge clk); #2; n++; end
    check("resp_v", 64'(io.resp_v_o), 64'd1);
    if (!e_stall) check("resp_latency", 64'(n), 64'd0);
    check("resp_type",    64'(io.resp_msg_type_o), 64'(e_type));
    check("resp_addr",    64'(io.resp_addr_o),     64'(e_addr));
    check("resp_size",    64'(io.resp_size_o),     64'(e_size));
    check("resp_payload", 64'(io.resp_payload_o),  64'(e_payload));
    check("resp_data",    io.resp_data_o,          e_data);
    check("finish",       64'(finish_o),           64'(m_finish));
    check("pass",         64'(pass_o),             64'(m_pass));
    check("all_finished", 64'(all_finished_o),     64'(&m_finish));
    check("error",        64'(error_o),            64'(m_error));
    check("no_yumi_busy", 64'(getchar_yumi_o),     64'd0);
    repeat (hold) begin
      @(negedge clk); #2;
      check("hold_v",    64'(io.resp_v_o), 64'd1);
      check("hold_data", io.resp_data_o,   e_data);
    end
    if (do_yumi) begin
      io.resp_yumi_i = 1'b1;
      @(posedge clk); #1;
      io.resp_yumi_i = 1'b0;
      check("resp_retired", 64'(io.resp_v_o), 64'd0);
    end
  endtask

  task automatic cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                     input logic [63:0] d, input logic [15:0] p,
                     input logic gv, input logic [7:0] gc);
    send_accept(t, a, s, d, p, gv, gc);
    wait_resp(1'b1, 0, 200);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_chars.size() != 0 && n < 200) begin @(negedge clk); #2; n++; end
    check("drain", 64'(exp_chars.size()), 64'd0);
  endtask

  logic [15:0] addr_tab [8] = '{16'h1000, 16'h1000, 16'h2000, 16'h3000,
                                16'h4000, 16'h2004, 16'h5000, 16'h3000};

  initial begin
    logic [63:0] d1, d2, c1, c2;
    io.cmd_msg_type_i = '0; io.cmd_addr_i = '0; io.cmd_size_i = '0;
    io.cmd_data_i = '0; io.cmd_payload_i = '0; io.cmd_v_i = 1'b0; io.resp_yumi_i = 1'b0;

    // Reset state
    char_mode = 1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_resp_v", 64'(io.resp_v_o), 64'd0);
    check("rst_char_v", 64'(char_v_o),    64'd0);
    check("rst_finish", 64'(finish_o),    64'd0);
    check("rst_error",  64'(error_o),     64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    check("rst_ready", 64'(io.cmd_ready_o), 64'd1);

    // Single putchar through a ready consumer
    cmd(4'd3, 40'h1000, 3'd0, 64'h41, 16'h0001, 1'b0, 8'h00);
    wait_drain();

    // Fill the FIFO, then stall on the fifth byte until the consumer wakes
    set_char_mode(0);
    for (int i = 0; i < fifo_els; i++)
      cmd(4'd3, 40'h1000, 3'd0, 64'(8'h31 + i), 16'(i), 1'b0, 8'h00);
    send_accept(4'd3, 40'h1000, 3'd0, 64'h5a, 16'h0055, 1'b0, 8'h00);
    check("stall_predicted", 64'(e_stall), 64'd1);
    repeat (4) begin
      @(negedge clk); #2;
      check("stall_no_resp", 64'(io.resp_v_o), 64'd0);
    end
    set_char_mode(1);
    wait_resp(1'b1, 0, 2);
    wait_drain();

    // Finish flags and pass status
    cmd(4'd3, 40'h2008, 3'd3, 64'h0, 16'h0a0a, 1'b0, 8'h00);
    cmd(4'd3, 40'h2000, 3'd3, 64'h1, 16'h0b0b, 1'b0, 8'h00);
    check("fin_flags",  64'(finish_o),       64'h3);
    check("fin_pass",   64'(pass_o),         64'h2);
    check("fin_all",    64'(all_finished_o), 64'd0);

    // Cycle counter: difference of two reads equals the accept-cycle gap
    cmd(4'd2, 40'h4000, 3'd3, 64'h0, 16'h0c01, 1'b0, 8'h00);
    d1 = io.resp_data_o; c1 = e_acc_cyc;
    repeat (10) @(negedge clk);
    cmd(4'd2, 40'h4000, 3'd3, 64'h0, 16'h0c02, 1'b0, 8'h00);
    d2 = io.resp_data_o; c2 = e_acc_cyc;
    check("cycle_delta", d2 - d1, c2 - c1);

    // Getchar with and without a host byte
    cmd(4'd2, 40'h3000, 3'd0, 64'h0, 16'h0d01, 1'b0, 8'h00);
    check("getchar_empty", io.resp_data_o, 64'hff);
    cmd(4'd2, 40'h3000, 3'd1, 64'h0, 16'h0d02, 1'b1, 8'h67);

    // Unmapped address and illegal message type
    cmd(4'd2, 40'h5000, 3'd3, 64'h0, 16'hbeef, 1'b0, 8'h00);
    cmd(4'd7, 40'h1000, 3'd0, 64'h99, 16'h1234, 1'b0, 8'h00);
    check("err_sticky", 64'(error_o), 64'd1);

    // Randomized commands against the model
    set_char_mode(2);
    for (int k = 0; k < 200; k++) begin
      logic [3:0]  t;
      logic [2:0]  s;
      logic [63:0] d;
      logic [15:0] a16;
      a16 = addr_tab[$urandom_range(0, 7)];
      if (a16 == 16'h2000) a16 = a16 + 16'(8 * $urandom_range(0, 5));
      t = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) d[7:0] = 8'h00;
      send_accept(t, {24'($urandom), a16}, s, d, 16'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom));
      wait_resp(1'b1, $urandom_range(0, 2), 300);
    end

    // Reset while a finish response is pending
    set_char_mode(1);
    wait_drain();
    send_accept(4'd3, 40'h2010, 3'd3, 64'h0, 16'h0e0e, 1'b0, 8'h00);
    wait_resp(1'b0, 0, 5);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_finish", 64'(finish_o),        64'd0);
    check("mid_rst_pass",   64'(pass_o),          64'd0);
    check("mid_rst_error",  64'(error_o),         64'd0);
    check("mid_rst_resp_v", 64'(io.resp_v_o),     64'd0);
    check("mid_rst_char_v", 64'(char_v_o),        64'd0);
    check("mid_rst_yumi",   64'(getchar_yumi_o),  64'd0);
    check("mid_rst_allfin", 64'(all_finished_o),  64'd0);
    m_finish = '0; m_pass = '0; m_error = 1'b0;
    exp_chars.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    check("post_rst_ready", 64'(io.cmd_ready_o), 64'd1);
    cmd(4'd2, 40'h4000, 3'd2, 64'h0, 16'h0f0f, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bp_io_host_responder.md
# bp_io_host_responder

Synthesizable responder for the BedRock I/O command stream that a BlackParrot chip emits toward its host. It accepts uncached load/store commands addressed to the host device region (putchar, per-core finish, getchar, cycle counter), performs the side effect, and returns exactly one BedRock response per command. It sits on the host side of the I/O link, behind the link endpoint, and replaces the nonsynthesizable host model on FPGA and emulation builds.

## Interface
- paddr_width_p, 40, command/response address width
- data_width_p, 64, command/response data width (fixed at 64)
- payload_width_p, 16, opaque header payload, echoed unchanged
- num_core_p, 4, number of finish slots
- char_fifo_els_p, 4, putchar FIFO depth (power of 2, ≥2)
- clk_i  in  1  clock; all state on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- cmd_msg_type_i  in  4  BedRock mem msg type (0 rd, 1 wr, 2 uc_rd, 3 uc_wr; others illegal)
- cmd_addr_i  in  paddr_width_p  byte address
- cmd_size_i  in  3  log2 bytes (0..3 legal)
- cmd_payload_i  in  payload_width_p  opaque
- cmd_data_i  in  data_width_p  store data
- cmd_v_i / cmd_ready_o  in / out  1  ready-valid command handshake
- resp_msg_type_o, resp_addr_o, resp_size_o, resp_payload_o  out  header echo
- resp_data_o  out  data_width_p  load data, zero for stores
- resp_v_o / resp_yumi_i  out / in  1  valid-yumi response handshake
- char_o  out  8  putchar byte; char_v_o out 1; char_ready_i in 1 (ready-valid)
- getchar_i  in  8; getchar_v_i in 1; getchar_yumi_o out 1
- finish_o  out  num_core_p  sticky finish flags
- pass_o  out  num_core_p  per-core pass status
- all_finished_o  out  1  &finish_o
- error_o  out  1  sticky, set on illegal type/size or unmapped address

## Operation
- Decode on cmd_addr_i[15:0]: 0x1000 putchar; 0x2000+8*i finish core i (i<num_core_p); 0x3000 getchar; 0x4000 cycle counter; anything else unmapped.
- FSM states IDLE, WAIT_CHAR, RESP.
- IDLE: cmd_ready_o=1. On cmd_v_i: latch header, capture response data, perform side effect, go RESP; if store to putchar and FIFO full, go WAIT_CHAR instead.
- WAIT_CHAR: cmd_ready_o=0; enqueue latched byte the first cycle FIFO is not full (including same-cycle dequeue), then RESP.
- RESP: resp_v_o=1, header fields = latched command; on resp_yumi_i go IDLE. cmd_ready_o=0.
- Putchar store: enqueue cmd_data_i[7:0]. FIFO drains on char_v_o & char_ready_i, FIFO order.
- Finish store core i: finish_o[i]<=1, pass_o[i]<=(cmd_data_i[7:0]==0); repeat writes overwrite pass_o[i].
- Getchar load: if getchar_v_i, data = zero-extended getchar_i and getchar_yumi_o pulses in the accept cycle; else data = all ones (-1).
- Cycle load: data = 64-bit free-running counter value in the accept cycle; counter wraps at 2^64.
- Load data masked to 8*2^size bits, zero-extended. Stores to getchar/cycle and loads from putchar/finish: no side effect, data 0.
- Illegal msg type, size>3, or unmapped address: error_o<=1, no side effect, response still returned with data 0.

## Timing
- Reset (async assert, any state): FSM IDLE, FIFO empty, counter 0, finish_o/pass_o/error_o 0, resp_v_o 0, char_v_o 0, getchar_yumi_o 0; cmd_ready_o 1 once reset deasserts.
- Command accepted cycle N → resp_v_o at N+1 (WAIT_CHAR adds cycles until space). One outstanding command; next accept no earlier than cycle after yumi.
- resp_* outputs registered, stable while resp_v_o=1 until yumi.
- finish_o/pass_o/error_o update visible cycle N+1, before or with the response.
- char_v_o asserted the cycle after the byte is enqueued.
- getchar_yumi_o is combinational from accept handshake only; never asserted outside IDLE.

## Test plan
- Reset: drop reset_n_i mid-RESP with finish_o=1 → all outputs 0 immediately, cmd_ready_o=1 after release.
- uc_wr 0x1000 data 0x41, char_ready_i=1 → resp_v_o next cycle, type 3, data 0; char_o=0x41.
- Fill FIFO with 4 chars, char_ready_i=0, send 5th 0x5A → no response; raise char_ready_i → response ≤2 cycles later, chars emerge in order ending 0x5A.
- uc_wr 0x2008 data 0 then 0x2000 data 1 (num_core_p=4) → finish_o=0b0011, pass_o=0b0010, all_finished_o=0.
- uc_rd 0x4000 size 3 twice, 10 cycles apart → data difference equals accept-cycle gap; uc_rd 0x3000 size 0 with getchar_v_i=0 → data 0xFF.
- uc_rd 0x5000 and msg type 7 → each returns response with data 0, error_o=1, payload echoed.
